ewrapper_tx_framer: RTL and testbench
=====================================

EWRAPPER_TX_FRAMER -- requirements
Module: ewrapper_tx_framer

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 CLK_DIV_IN  input  1  slow core clock; all logic on its rising edge; single clock domain.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 EMESH_ACCESS_IN  input  1  transaction valid.
REQ-005 EMESH_WRITE_IN  input  1  write flag.
REQ-006 EMESH_DATAMODE_IN  input  2  datamode.
REQ-007 EMESH_CTRLMODE_IN  input  4  ctrlmode.
REQ-008 EMESH_DSTADDR_IN  input  32  destination address.
REQ-009 EMESH_DATA_IN  input  32  data.
REQ-010 EMESH_SRCADDR_IN  input  32  source address.
REQ-011 EMESH_WAIT_OUT  output  1  backpressure to the source; high = transaction not accepted.
REQ-012 TX_WAIT_IN  input  1  link-partner wait, already synchronous to CLK_DIV_IN.
REQ-013 DATA_OUT_TO_IO  output  72  registered beat to the serializer: [71:64] frame lane, [63:0] eight data bytes; byte n on [63-8n:56-8n]; MSB of each byte is transmitted first.

Function
REQ-014 SHALL accept a transaction when EMESH_ACCESS_IN=1 and EMESH_WAIT_OUT=0 in the same cycle.
REQ-015 SHALL buffer accepted transactions in a 2-entry FIFO; EMESH_WAIT_OUT = FIFO full (combinational from registered state only).
REQ-016 SHALL run FSM IDLE/BEAT0/BEAT1: IDLE->BEAT0 when FIFO non-empty and TX_WAIT_IN=0; BEAT0->BEAT1 unconditionally; BEAT1->BEAT0 when FIFO holds another entry and TX_WAIT_IN=0, else ->IDLE.
REQ-017 TX_WAIT_IN SHALL only block packet starts; a started packet always completes both beats.
REQ-018 FIFO entry SHALL be popped on the BEAT1 cycle; simultaneous push and pop on a full FIFO SHALL not be permitted (WAIT_OUT already high); push and pop in the same cycle otherwise SHALL leave occupancy unchanged.
REQ-019 Beat0 bytes: b0={CTRLMODE,DSTADDR[31:28]}, b1..b3=DSTADDR[27:4], b4={DSTADDR[3:0],DATAMODE,WRITE,1'b1}, b5..b7=DATA[31:8]; frame lane 8'h7F.
REQ-020 Beat1 bytes: b0=DATA[7:0], b1..b4=SRCADDR[31:0], b5..b7=8'h00; frame lane 8'hFF.
REQ-021 Idle beat SHALL be all 72 bits zero.
REQ-022 Latency: transaction accepted in cycle N into empty FIFO with FSM IDLE and TX_WAIT_IN=0 SHALL appear as beat0 at N+1, beat1 at N+2.
REQ-023 Back-to-back packets SHALL sustain one packet per two cycles with no idle beat between; frame 8'hFF->8'h7F transition marks the new start.
REQ-024 No line inversion SHALL be applied here; polarity handling belongs to the serializer.

Reset
REQ-025 RESET SHALL asynchronously clear FIFO pointers/occupancy, force FSM to IDLE, DATA_OUT_TO_IO to 72'h0, EMESH_WAIT_OUT to 0.
REQ-026 RESET asserted mid-packet SHALL drop the partial and all buffered packets; first packet after release starts fresh at BEAT0.

Configuration
REQ-027 With ETX_PKTCNT_EN defined, SHALL add output TX_PKT_CNT [15:0], incremented on each BEAT1 cycle, wrapping 16'hFFFF->0, cleared by RESET.
REQ-028 Without ETX_PKTCNT_EN, TX_PKT_CNT port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 Single write: ctrlmode=4'hA, dstaddr=32'h8080_0004, datamode=2'b10, write=1, data=32'hDEAD_BEEF, srcaddr=32'h1234_5678 at N -> N+1 DATA_OUT=72'h7F_A8_08_00_00_4B_DE_AD_BE, N+2 72'hFF_EF_12_34_56_78_00_00_00, N+3 72'h0.
REQ-030 Three transactions on consecutive cycles -> EMESH_WAIT_OUT high when FIFO full, packets emitted back-to-back, 6 consecutive framed beats, no loss or reordering.
REQ-031 TX_WAIT_IN raised during BEAT0 -> BEAT1 still emitted; next packet held (idle beats) until TX_WAIT_IN low, then BEAT0 next cycle.
REQ-032 RESET pulsed during BEAT0 with 2 buffered -> DATA_OUT=0 immediately, EMESH_WAIT_OUT=0, no beats after release until new access.
REQ-033 ETX_PKTCNT_EN defined, 65537 packets -> TX_PKT_CNT=1; undefined build elaborates without the port.

Source files
------------

// File: rtl/ewrapper_tx_framer.sv
// eMesh transmit framer: buffers transactions in a 2-entry FIFO and emits each as two 72-bit beats.
// Optional build macro ETX_PKTCNT_EN adds a free-running TX_PKT_CNT packet counter output.
module ewrapper_tx_framer (
  input  logic        CLK_DIV_IN,
  input  logic        RESET,
  input  logic        EMESH_ACCESS_IN,
  input  logic        EMESH_WRITE_IN,
  input  logic [1:0]  EMESH_DATAMODE_IN,
  input  logic [3:0]  EMESH_CTRLMODE_IN,
  input  logic [31:0] EMESH_DSTADDR_IN,
  input  logic [31:0] EMESH_DATA_IN,
  input  logic [31:0] EMESH_SRCADDR_IN,
  output logic        EMESH_WAIT_OUT,
  input  logic        TX_WAIT_IN,
  output logic [71:0] DATA_OUT_TO_IO
`ifdef ETX_PKTCNT_EN
  ,
  output logic [15:0] TX_PKT_CNT
`endif
);

  // state   | meaning
  // S_IDLE  | no packet on the wire, zero beat driven
  // S_BEAT0 | first beat (frame 8'h7F) on DATA_OUT_TO_IO
  // S_BEAT1 | second beat (frame 8'hFF) on DATA_OUT_TO_IO; head entry popped
  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;

  typedef struct packed {
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [1:0]  datamode;
    logic        write;
    logic [31:0] data;
    logic [31:0] srcaddr;
  } txn_t;

  function automatic logic [71:0] beat0(input txn_t t);
    return {8'h7F, t.ctrlmode, t.dstaddr, t.datamode, t.write, 1'b1, t.data[31:8]};
  endfunction

  function automatic logic [71:0] beat1(input txn_t t);
    return {8'hFF, t.data[7:0], t.srcaddr, 24'h0};
  endfunction

  state_t      state_q, state_d;
  txn_t        fifo_q [2];
  txn_t        fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [71:0] data_out_q, data_out_d;
  txn_t        in_txn;
  txn_t        beat0_src;
  logic        push;
  logic        pop;

  assign EMESH_WAIT_OUT = (count_q == 2'd2);
  assign DATA_OUT_TO_IO = data_out_q;

  always_comb begin
    in_txn     = '{ctrlmode: EMESH_CTRLMODE_IN, dstaddr: EMESH_DSTADDR_IN,
                   datamode: EMESH_DATAMODE_IN, write: EMESH_WRITE_IN,
                   data: EMESH_DATA_IN, srcaddr: EMESH_SRCADDR_IN};
    push       = EMESH_ACCESS_IN && !EMESH_WAIT_OUT;
    pop        = (state_q == S_BEAT1);
    state_d    = S_IDLE;
    beat0_src  = fifo_q[rd_ptr_q];
    data_out_d = '0;

    case (state_q)
      S_IDLE: begin
        // An empty FIFO bypasses the incoming transaction so it goes out the next cycle.
        if (count_q == 2'd0) beat0_src = in_txn;
        if ((count_q != 2'd0 || push) && !TX_WAIT_IN) state_d = S_BEAT0;
      end
      S_BEAT0: state_d = S_BEAT1;
      S_BEAT1: begin
        beat0_src = fifo_q[~rd_ptr_q];
        if (count_q == 2'd2 && !TX_WAIT_IN) state_d = S_BEAT0;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_BEAT0: data_out_d = beat0(beat0_src);
      S_BEAT1: data_out_d = beat1(fifo_q[rd_ptr_q]);
      default: data_out_d = '0;
    endcase

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = in_txn;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge CLK_DIV_IN or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge CLK_DIV_IN) begin
    fifo_q <= fifo_d;
  end

`ifdef ETX_PKTCNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q + {15'd0, (state_q == S_BEAT1)};
  end

  always_ff @(posedge CLK_DIV_IN or posedge RESET) begin
    if (RESET) pkt_cnt_q <= '0;
    else       pkt_cnt_q <= pkt_cnt_d;
  end

  assign TX_PKT_CNT = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_ewrapper_tx_framer.sv
// Self-checking bench for ewrapper_tx_framer: vector table, beat scoreboard and multi-cycle corner sequences.
// Build with ETX_PKTCNT_EN defined to also check TX_PKT_CNT.
module tb_ewrapper_tx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        access, write, tx_wait;
  logic [1:0]  datamode;
  logic [3:0]  ctrlmode;
  logic [31:0] dstaddr, data, srcaddr;
  logic        wait_out;
  logic [71:0] data_out;
`ifdef ETX_PKTCNT_EN
  logic [15:0] pkt_cnt;
`endif

  ewrapper_tx_framer dut (
    .CLK_DIV_IN        (clk),
    .RESET             (rst),
    .EMESH_ACCESS_IN   (access),
    .EMESH_WRITE_IN    (write),
    .EMESH_DATAMODE_IN (datamode),
    .EMESH_CTRLMODE_IN (ctrlmode),
    .EMESH_DSTADDR_IN  (dstaddr),
    .EMESH_DATA_IN     (data),
    .EMESH_SRCADDR_IN  (srcaddr),
    .EMESH_WAIT_OUT    (wait_out),
    .TX_WAIT_IN        (tx_wait),
    .DATA_OUT_TO_IO    (data_out)
`ifdef ETX_PKTCNT_EN
    ,
    .TX_PKT_CNT        (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] dst;
    logic [1:0]  dm;
    logic        wr;
    logic [31:0] dat;
    logic [31:0] src;
    logic [71:0] exp0;
    logic [71:0] exp1;
  } vec_t;

  vec_t        vecs [5];
  logic [71:0] sb_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          wait_seen;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every non-zero beat must be the next expected one.
  always @(negedge clk) begin
    if (!rst && data_out !== 72'h0) begin
      if (sb_q.size() == 0) check("unexpected_beat", data_out, 72'h0);
      else check("sb_beat", data_out, sb_q.pop_front());
    end
  end

  // Called right after a rising edge; returns right after the edge on which the transaction was accepted.
  task automatic send(input vec_t v);
    bit accepted;
    accepted = 0;
    access = 1'b1; ctrlmode = v.ctrl; dstaddr = v.dst; datamode = v.dm;
    write = v.wr; data = v.dat; srcaddr = v.src;
    for (int t = 0; t < 20 && !accepted; t++) begin
      @(negedge clk);
      if (!wait_out) begin
        sb_q.push_back(v.exp0);
        sb_q.push_back(v.exp1);
        accepted = 1;
      end else begin
        wait_seen = 1;
      end
      @(posedge clk); #1;
    end
    access = 1'b0;
    if (!accepted) check("accept_timeout", 72'd0, 72'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 72'(sb_q.size()), 72'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    vecs[0] = '{4'hA, 32'h8080_0004, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678,
                72'h7F_A8_08_00_00_4B_DE_AD_BE, 72'hFF_EF_12_34_56_78_00_00_00};
    vecs[1] = '{4'h0, 32'h0000_0000, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000,
                72'h7F_00_00_00_00_01_00_00_00, 72'hFF_00_00_00_00_00_00_00_00};
    vecs[2] = '{4'hF, 32'hFFFF_FFFF, 2'b11, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                72'h7F_FF_FF_FF_FF_FF_FF_FF_FF, 72'hFF_FF_FF_FF_FF_FF_00_00_00};
    vecs[3] = '{4'h5, 32'h1234_5678, 2'b01, 1'b0, 32'h0102_0304, 32'hA5A5_5A5A,
                72'h7F_51_23_45_67_85_01_02_03, 72'hFF_04_A5_A5_5A_5A_00_00_00};
    vecs[4] = '{4'h3, 32'hC000_000F, 2'b00, 1'b1, 32'h8000_0001, 32'h0000_0001,
                72'h7F_3C_00_00_00_F3_80_00_00, 72'hFF_01_00_00_00_01_00_00_00};

    rst = 1'b1; access = 1'b0; write = 1'b0; tx_wait = 1'b0;
    datamode = '0; ctrlmode = '0; dstaddr = '0; data = '0; srcaddr = '0;
    wait_seen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", data_out, 72'h0);
    check("reset_wait", 72'(wait_out), 72'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write: exact latency, beats and trailing idle.
    send(vecs[0]);
    @(negedge clk); check("single_beat0", data_out, vecs[0].exp0);
    @(posedge clk); #1;
    @(negedge clk); check("single_beat1", data_out, vecs[0].exp1);
    @(posedge clk); #1;
    @(negedge clk); check("single_idle", data_out, 72'h0);
    drain();

    // Table: all vectors back-to-back, expecting an unbroken run of framed beats.
    wait_seen = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(vecs[i]);
      end
      begin
        int run, t;
        run = 0; t = 0;
        while (data_out === 72'h0 && t < 20) begin @(negedge clk); t++; end
        while (data_out !== 72'h0 && run < 20) begin
          check("frame_alt", 72'(data_out[71:64]), (run % 2 == 0) ? 72'h7F : 72'hFF);
          run++;
          @(negedge clk);
        end
        check("b2b_run_len", 72'(run), 72'd10);
      end
    join
    check("wait_when_full", 72'(wait_seen), 72'd1);
    drain();

    // TX_WAIT_IN raised during BEAT0: BEAT1 completes, next packet held until release.
    send(vecs[1]);
    tx_wait = 1'b1;
    send(vecs[2]);
    @(negedge clk); check("txwait_beat1_done", data_out, vecs[1].exp1);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk); check("txwait_hold_idle", data_out, 72'h0);
    end
    @(posedge clk); #1;
    tx_wait = 1'b0;
    @(negedge clk); check("txwait_release_idle", data_out, 72'h0);
    @(posedge clk); #1;
    @(negedge clk); check("txwait_release_beat0", data_out, vecs[2].exp0);
    drain();

    // Reset during BEAT0 with two packets buffered.
    tx_wait = 1'b1;
    send(vecs[3]);
    send(vecs[4]);
    tx_wait = 1'b0;
    @(negedge clk); check("full_wait_high", 72'(wait_out), 72'd1);
    @(posedge clk); #1;
    @(negedge clk); check("pre_reset_beat0", data_out, vecs[3].exp0);
    #2 rst = 1'b1;
    sb_q.delete();
    #1;
    check("async_reset_data", data_out, 72'h0);
    check("async_reset_wait", 72'(wait_out), 72'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk); check("post_reset_idle", data_out, 72'h0);
      @(posedge clk); #1;
    end
    send(vecs[2]);
    @(negedge clk); check("post_reset_beat0", data_out, vecs[2].exp0);
    @(posedge clk); #1;
    drain();
`ifdef ETX_PKTCNT_EN
    check("pkt_cnt", 72'(pkt_cnt), 72'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
